riscv_control_unit: RTL and testbench

// - Central control path of the 5-stage RV32I pipeline (fetch/decode/execute/mem/wb).
// - Decodes the instruction in decode and drives the decode-stage selects (pc_sel, imm_sel, br_op).
// - Carries execute, mem and write-back control through internal pipeline registers, aligned to
//   the instruction's stage.

---
 rtl/riscv_control_unit.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_riscv_control_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_control_unit.sv
// riscv_control_unit: control path of a 5-stage RV32I pipeline.
// Decodes the instruction in decode into the decode-stage selects
// (pc_sel, imm_sel, br_op). It then carries the execute, mem and write-back
// controls through the EXE, MEM and WB stage registers, so each registered
// output lines up with its instruction's stage.
// Optional feature macro: CTRL_FLUSH_EN. When it is defined, the unit adds a
// flush_decode output and squashes the instruction that follows any redirect.
//
// Decode choices for fields that the instruction class leaves open:
//   BRANCH -> A=pc, B=imm, ADD   (the ALU forms the branch target)
//   JAL    -> A=pc, B=imm, ADD
//   JALR   -> A=rs1, B=imm, ADD
//   STORE  -> B=imm              (the address is rs1 + imm)
//   LUI    -> B=imm
//   OP     -> imm_sel=I          (this value is unused)
module riscv_control_unit #(
  parameter int XLEN      = 32,
  parameter int PC_SEL_W  = 2,
  parameter int IMM_SEL_W = 3,
  parameter int ALU_OP_W  = 4,
  parameter int WB_SEL_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XLEN-1:0]      instr_decode,
  input  logic                 br_true,
  output logic [ALU_OP_W-1:0]  br_op,
  output logic [PC_SEL_W-1:0]  pc_sel,
  output logic [IMM_SEL_W-1:0] imm_sel,
  output logic                 a_sel_exe,
  output logic                 b_sel_exe,
  output logic [ALU_OP_W-1:0]  alu_sel_exe,
  output logic                 mem_en_mem,
  output logic                 mem_wr_mem,
  output logic [WB_SEL_W-1:0]  wb_sel_wb,
  output logic                 reg_en_wb
`ifdef CTRL_FLUSH_EN
  ,
  output logic                 flush_decode
`endif
);

  // Major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // ALU operation codes
  localparam logic [ALU_OP_W-1:0] ALU_ADD    = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB    = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_SLL    = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_SLT    = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_SLTU   = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_XOR    = ALU_OP_W'(5);
  localparam logic [ALU_OP_W-1:0] ALU_SRL    = ALU_OP_W'(6);
  localparam logic [ALU_OP_W-1:0] ALU_SRA    = ALU_OP_W'(7);
  localparam logic [ALU_OP_W-1:0] ALU_OR     = ALU_OP_W'(8);
  localparam logic [ALU_OP_W-1:0] ALU_AND    = ALU_OP_W'(9);
  localparam logic [ALU_OP_W-1:0] ALU_PASS_B = ALU_OP_W'(10);

  // Next-PC selects
  localparam logic [PC_SEL_W-1:0] PC_PLUS4  = PC_SEL_W'(0);
  localparam logic [PC_SEL_W-1:0] PC_BRANCH = PC_SEL_W'(1);
  localparam logic [PC_SEL_W-1:0] PC_JAL    = PC_SEL_W'(2);
  localparam logic [PC_SEL_W-1:0] PC_JALR   = PC_SEL_W'(3);

  // Immediate formats
  localparam logic [IMM_SEL_W-1:0] IMM_I = IMM_SEL_W'(0);
  localparam logic [IMM_SEL_W-1:0] IMM_S = IMM_SEL_W'(1);
  localparam logic [IMM_SEL_W-1:0] IMM_B = IMM_SEL_W'(2);
  localparam logic [IMM_SEL_W-1:0] IMM_U = IMM_SEL_W'(3);
  localparam logic [IMM_SEL_W-1:0] IMM_J = IMM_SEL_W'(4);

  // Write-back sources
  localparam logic [WB_SEL_W-1:0] WB_ALU = WB_SEL_W'(0);
  localparam logic [WB_SEL_W-1:0] WB_MEM = WB_SEL_W'(1);
  localparam logic [WB_SEL_W-1:0] WB_PC4 = WB_SEL_W'(2);

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic [4:0] rd;

  assign opcode    = instr_decode[6:0];
  assign funct3    = instr_decode[14:12];
  assign funct7_b5 = instr_decode[30];
  assign rd        = instr_decode[11:7];

  // The register-source and upper immediate bits belong to the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr_decode[XLEN-1:31], instr_decode[29:15]};

  // Maps funct3 (plus bit 30) to an ALU op; SUB exists only for the register form
  function automatic logic [ALU_OP_W-1:0] alu_from_funct(input logic [2:0] f3,
                                                         input logic       b30,
                                                         input logic       is_reg);
    logic [ALU_OP_W-1:0] op;
    case (f3)
      3'b000:  op = (is_reg && b30) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = b30 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Raw decode bundle, before any squash
  logic [PC_SEL_W-1:0]  pc_sel_raw;
  logic [IMM_SEL_W-1:0] imm_sel_raw;
  logic [ALU_OP_W-1:0]  br_op_raw;
  logic                 a_sel_raw;
  logic                 b_sel_raw;
  logic [ALU_OP_W-1:0]  alu_raw;
  logic                 mem_en_raw;
  logic                 mem_wr_raw;
  logic [WB_SEL_W-1:0]  wb_sel_raw;
  logic                 reg_en_raw;

  // Decode the instruction class into a control bundle. Unknown opcodes fall to the NOP bundle.
  always_comb begin
    pc_sel_raw  = PC_PLUS4;
    imm_sel_raw = IMM_I;
    br_op_raw   = '0;
    a_sel_raw   = 1'b0;
    b_sel_raw   = 1'b0;
    alu_raw     = ALU_ADD;
    mem_en_raw  = 1'b0;
    mem_wr_raw  = 1'b0;
    wb_sel_raw  = WB_ALU;
    reg_en_raw  = 1'b0;
    case (opcode)
      OPC_OP: begin
        alu_raw    = alu_from_funct(funct3, funct7_b5, 1'b1);
        reg_en_raw = 1'b1;
      end
      OPC_OP_IMM: begin
        b_sel_raw  = 1'b1;
        alu_raw    = alu_from_funct(funct3, funct7_b5, 1'b0);
        reg_en_raw = 1'b1;
      end
      OPC_LOAD: begin
        b_sel_raw  = 1'b1;
        mem_en_raw = 1'b1;
        wb_sel_raw = WB_MEM;
        reg_en_raw = 1'b1;
      end
      OPC_STORE: begin
        imm_sel_raw = IMM_S;
        b_sel_raw   = 1'b1;
        mem_en_raw  = 1'b1;
        mem_wr_raw  = 1'b1;
      end
      OPC_BRANCH: begin
        imm_sel_raw = IMM_B;
        br_op_raw   = {{(ALU_OP_W-3){1'b0}}, funct3};
        a_sel_raw   = 1'b1;
        b_sel_raw   = 1'b1;
        pc_sel_raw  = br_true ? PC_BRANCH : PC_PLUS4;
      end
      OPC_LUI: begin
        imm_sel_raw = IMM_U;
        b_sel_raw   = 1'b1;
        alu_raw     = ALU_PASS_B;
        reg_en_raw  = 1'b1;
      end
      OPC_AUIPC: begin
        imm_sel_raw = IMM_U;
        a_sel_raw   = 1'b1;
        b_sel_raw   = 1'b1;
        reg_en_raw  = 1'b1;
      end
      OPC_JAL: begin
        imm_sel_raw = IMM_J;
        a_sel_raw   = 1'b1;
        b_sel_raw   = 1'b1;
        wb_sel_raw  = WB_PC4;
        reg_en_raw  = 1'b1;
        pc_sel_raw  = PC_JAL;
      end
      OPC_JALR: begin
        b_sel_raw   = 1'b1;
        wb_sel_raw  = WB_PC4;
        reg_en_raw  = 1'b1;
        pc_sel_raw  = PC_JALR;
      end
      default: begin
        pc_sel_raw = PC_PLUS4;
      end
    endcase
    if (rd == 5'd0) reg_en_raw = 1'b0;
  end

  // Final decode bundle that drives the outputs and the EXE register
  logic                 a_sel_dec;
  logic                 b_sel_dec;
  logic [ALU_OP_W-1:0]  alu_dec;
  logic                 mem_en_dec;
  logic                 mem_wr_dec;
  logic [WB_SEL_W-1:0]  wb_sel_dec;
  logic                 reg_en_dec;

`ifdef CTRL_FLUSH_EN
  // Set by a redirect. It turns the next decode slot into a NOP.
  logic squash_q;

  // Remember whether this cycle redirects fetch. Reset drops any pending squash.
  always_ff @(posedge clk) begin
    if (rst) squash_q <= 1'b0;
    else     squash_q <= (pc_sel != PC_PLUS4);
  end

  // While a squash is pending, replace the decode bundle, including its selects, with NOP.
  always_comb begin
    pc_sel     = pc_sel_raw;
    imm_sel    = imm_sel_raw;
    br_op      = br_op_raw;
    a_sel_dec  = a_sel_raw;
    b_sel_dec  = b_sel_raw;
    alu_dec    = alu_raw;
    mem_en_dec = mem_en_raw;
    mem_wr_dec = mem_wr_raw;
    wb_sel_dec = wb_sel_raw;
    reg_en_dec = reg_en_raw;
    if (squash_q) begin
      pc_sel     = PC_PLUS4;
      imm_sel    = IMM_I;
      br_op      = '0;
      a_sel_dec  = 1'b0;
      b_sel_dec  = 1'b0;
      alu_dec    = ALU_ADD;
      mem_en_dec = 1'b0;
      mem_wr_dec = 1'b0;
      wb_sel_dec = WB_ALU;
      reg_en_dec = 1'b0;
    end
  end

  assign flush_decode = (pc_sel != PC_PLUS4);
`else
  assign pc_sel     = pc_sel_raw;
  assign imm_sel    = imm_sel_raw;
  assign br_op      = br_op_raw;
  assign a_sel_dec  = a_sel_raw;
  assign b_sel_dec  = b_sel_raw;
  assign alu_dec    = alu_raw;
  assign mem_en_dec = mem_en_raw;
  assign mem_wr_dec = mem_wr_raw;
  assign wb_sel_dec = wb_sel_raw;
  assign reg_en_dec = reg_en_raw;
`endif

  // EXE stage register. It keeps only the fields that are still needed downstream.
  logic                mem_en_exe;
  logic                mem_wr_exe;
  logic [WB_SEL_W-1:0] wb_sel_exe;
  logic                reg_en_exe;
  logic [WB_SEL_W-1:0] wb_sel_mem;
  logic                reg_en_mem;

  // Advance control one stage per cycle. Reset loads NOP into every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sel_exe   <= 1'b0;
      b_sel_exe   <= 1'b0;
      alu_sel_exe <= ALU_ADD;
      mem_en_exe  <= 1'b0;
      mem_wr_exe  <= 1'b0;
      wb_sel_exe  <= WB_ALU;
      reg_en_exe  <= 1'b0;
      mem_en_mem  <= 1'b0;
      mem_wr_mem  <= 1'b0;
      wb_sel_mem  <= WB_ALU;
      reg_en_mem  <= 1'b0;
      wb_sel_wb   <= WB_ALU;
      reg_en_wb   <= 1'b0;
    end else begin
      a_sel_exe   <= a_sel_dec;
      b_sel_exe   <= b_sel_dec;
      alu_sel_exe <= alu_dec;
      mem_en_exe  <= mem_en_dec;
      mem_wr_exe  <= mem_wr_dec;
      wb_sel_exe  <= wb_sel_dec;
      reg_en_exe  <= reg_en_dec;
      mem_en_mem  <= mem_en_exe;
      mem_wr_mem  <= mem_wr_exe;
      wb_sel_mem  <= wb_sel_exe;
      reg_en_mem  <= reg_en_exe;
      wb_sel_wb   <= wb_sel_mem;
      reg_en_wb   <= reg_en_mem;
    end
  end

endmodule

// File: tb/tb_riscv_control_unit.sv
// tb_riscv_control_unit: scoreboard bench for riscv_control_unit.
// The stimulus process drives one instruction per cycle and checks the
// combinational decode selects. It also queues the control bundle that the
// EXE register should capture. The monitor process pops one entry per clock
// and replays it through a three-deep delay line to predict EXE, MEM and WB.
module tb_riscv_control_unit;

  typedef struct packed {
    logic [1:0] pc_sel;
    logic [2:0] imm_sel;
    logic [3:0] br_op;
    logic       a_sel;
    logic       b_sel;
    logic [3:0] alu;
    logic       mem_en;
    logic       mem_wr;
    logic [1:0] wb_sel;
    logic       reg_en;
  } ctrl_t;

  typedef struct packed {
    logic  rst;
    ctrl_t c;
  } entry_t;

  typedef enum {C_ILL, C_OP, C_OPIMM, C_LOAD, C_STORE, C_BR, C_LUI, C_AUIPC, C_JAL, C_JALR} cls_t;

  localparam int N_CYCLES = 400;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_decode;
  logic        br_true;
  logic [3:0]  br_op;
  logic [1:0]  pc_sel;
  logic [2:0]  imm_sel;
  logic        a_sel_exe;
  logic        b_sel_exe;
  logic [3:0]  alu_sel_exe;
  logic        mem_en_mem;
  logic        mem_wr_mem;
  logic [1:0]  wb_sel_wb;
  logic        reg_en_wb;
`ifdef CTRL_FLUSH_EN
  logic        flush_decode;
`endif

  int checks   = 0;
  int failures = 0;
  entry_t sb_q[$];

  riscv_control_unit dut (
    .clk          (clk),
    .rst          (rst),
    .instr_decode (instr_decode),
    .br_true      (br_true),
    .br_op        (br_op),
    .pc_sel       (pc_sel),
    .imm_sel      (imm_sel),
    .a_sel_exe    (a_sel_exe),
    .b_sel_exe    (b_sel_exe),
    .alu_sel_exe  (alu_sel_exe),
    .mem_en_mem   (mem_en_mem),
    .mem_wr_mem   (mem_wr_mem),
    .wb_sel_wb    (wb_sel_wb),
    .reg_en_wb    (reg_en_wb)
`ifdef CTRL_FLUSH_EN
    ,
    .flush_decode (flush_decode)
`endif
  );

  always #5 clk = ~clk;

  function automatic cls_t classify(input logic [6:0] op);
    case (op)
      7'h33:   return C_OP;
      7'h13:   return C_OPIMM;
      7'h03:   return C_LOAD;
      7'h23:   return C_STORE;
      7'h63:   return C_BR;
      7'h37:   return C_LUI;
      7'h17:   return C_AUIPC;
      7'h6F:   return C_JAL;
      7'h67:   return C_JALR;
      default: return C_ILL;
    endcase
  endfunction

  // Reference model: each field follows directly from the instruction class rules.
  function automatic ctrl_t ref_model(input logic [31:0] ins, input logic brt);
    ctrl_t c;
    cls_t  k;
    int    alu_tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int    f3;
    logic  b30;
    int    alu;
    c   = '0;
    k   = classify(ins[6:0]);
    f3  = int'(ins[14:12]);
    b30 = ins[30];
    if (k == C_STORE)                      c.imm_sel = 3'd1;
    else if (k == C_BR)                    c.imm_sel = 3'd2;
    else if (k == C_LUI || k == C_AUIPC)   c.imm_sel = 3'd3;
    else if (k == C_JAL)                   c.imm_sel = 3'd4;
    c.br_op  = (k == C_BR) ? {1'b0, ins[14:12]} : 4'd0;
    c.a_sel  = (k == C_AUIPC || k == C_JAL || k == C_BR);
    c.b_sel  = !(k == C_ILL || k == C_OP);
    alu = 0;
    if (k == C_OP || k == C_OPIMM) begin
      alu = alu_tab[f3];
      if (f3 == 5 && b30) alu = 7;
      if (f3 == 0 && b30 && k == C_OP) alu = 1;
    end else if (k == C_LUI) begin
      alu = 10;
    end
    c.alu    = 4'(alu);
    c.mem_en = (k == C_LOAD || k == C_STORE);
    c.mem_wr = (k == C_STORE);
    c.wb_sel = (k == C_LOAD) ? 2'd1 : ((k == C_JAL || k == C_JALR) ? 2'd2 : 2'd0);
    c.reg_en = (k inside {C_OP, C_OPIMM, C_LOAD, C_LUI, C_AUIPC, C_JAL, C_JALR}) &&
               (ins[11:7] != 5'd0);
    if (k == C_JALR)          c.pc_sel = 2'd3;
    else if (k == C_JAL)      c.pc_sel = 2'd2;
    else if (k == C_BR && brt) c.pc_sel = 2'd1;
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] gen_instr();
    logic [6:0]  opcs [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67};
    logic [31:0] r;
    int          sel;
    r   = $urandom();
    sel = $urandom_range(0, 11);
    if (sel == 0) return r;
    if (sel == 1) return 32'h0;
    return {r[31:7], opcs[$urandom_range(0, 8)]};
  endfunction

  // Drive one cycle of inputs, check the decode selects and queue the EXE-bound bundle.
  task automatic applyStimulus(input logic r, input logic [31:0] ins, input logic brt,
                               inout logic pending);
    ctrl_t  e;
    entry_t en;
    rst          = r;
    instr_decode = ins;
    br_true      = brt;
    #1;
    e = ref_model(ins, brt);
`ifdef CTRL_FLUSH_EN
    if (pending) e = '0;
    checkOutput("flush_decode", 32'(flush_decode), 32'(e.pc_sel != 2'd0));
`endif
    checkOutput("pc_sel", 32'(pc_sel), 32'(e.pc_sel));
    checkOutput("imm_sel", 32'(imm_sel), 32'(e.imm_sel));
    checkOutput("br_op", 32'(br_op), 32'(e.br_op));
    en.rst = r;
    en.c   = r ? ctrl_t'('0) : e;
    sb_q.push_back(en);
    pending = r ? 1'b0 : (e.pc_sel != 2'd0);
  endtask

  task automatic run_stimulus();
    logic        pending = 1'b0;
    logic [31:0] dir [8] = '{32'h00500093, 32'h0000A103, 32'h0020A223, 32'h00000463,
                             32'h00000463, 32'h010000EF, 32'h00008067, 32'h00000000};
    logic        dbr [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int          n = 0;
    // Two reset cycles first, then the directed vectors separated by bubbles, then random traffic.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 32'h0, 1'b0, pending);
      @(negedge clk); n++;
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, dir[i], dbr[i], pending);
      @(negedge clk); n++;
      applyStimulus(1'b0, 32'h0, 1'b0, pending);
      @(negedge clk); n++;
    end
    while (n < N_CYCLES) begin
      applyStimulus(($urandom_range(0, 39) == 0), gen_instr(), 1'($urandom()), pending);
      @(negedge clk); n++;
    end
  endtask

  // Monitor: one queued entry per clock edge, delayed through EXE, MEM and WB.
  task automatic run_monitor();
    ctrl_t  h0 = '0, h1 = '0, h2 = '0;
    logic   seen_rst = 1'b0;
    entry_t en;
    for (int i = 0; i < N_CYCLES; i++) begin
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        checkOutput("scoreboard_empty", 32'd1, 32'd0);
        continue;
      end
      en = sb_q.pop_front();
      if (en.rst) begin
        h0 = '0; h1 = '0; h2 = '0;
        seen_rst = 1'b1;
      end else begin
        h2 = h1; h1 = h0; h0 = en.c;
      end
      if (seen_rst) begin
        checkOutput("a_sel_exe", 32'(a_sel_exe), 32'(h0.a_sel));
        checkOutput("b_sel_exe", 32'(b_sel_exe), 32'(h0.b_sel));
        checkOutput("alu_sel_exe", 32'(alu_sel_exe), 32'(h0.alu));
        checkOutput("mem_en_mem", 32'(mem_en_mem), 32'(h1.mem_en));
        checkOutput("mem_wr_mem", 32'(mem_wr_mem), 32'(h1.mem_wr));
        checkOutput("wb_sel_wb", 32'(wb_sel_wb), 32'(h2.wb_sel));
        checkOutput("reg_en_wb", 32'(reg_en_wb), 32'(h2.reg_en));
      end
    end
  endtask

  initial begin
    fork
      run_stimulus();
      run_monitor();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
